// File: rtl/extremum_window_controller_if.sv
// Streaming sample bus shared by the measured input and the pass-through output.
interface extremum_window_controller_if #(
  parameter int W = 32
) ();
  logic         tvalid;
  logic [W-1:0] tdata;
  logic         tready;

  modport master (output tvalid, output tdata);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/extremum_window_controller.sv
// Windowed signed min/max tracker that derives a range shift from the peak and
// publishes shifted thresholds; the sample stream passes straight through.
//
// state   | meaning
// IDLE    | waiting for start pulse or continuous mode
// MEASURE | accepting samples, tracking run_min/run_max
// EVAL    | computing shift from peak width; results register on exit
// UPDATE  | done pulse with fresh results; re-arm or return to IDLE
module extremum_window_controller #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int MAX_LOG_COUNT    = 20
) (
  input  logic                              SYS_aclk_i,
  input  logic                              SYS_aresetn_i,
  input  logic                              CTRL_start_i,
  input  logic                              CTRL_continuous_i,
  input  logic [4:0]                        CTRL_log_count_i,
  input  logic [5:0]                        CTRL_target_bits_i,
  output logic                              CTRL_busy_o,
  output logic                              CTRL_done_o,
  output logic [31:0]                       CTRL_window_count_o,
  output logic [5:0]                        EF_log_shift_o,
  output logic [AXIS_TDATA_WIDTH-1:0]       EF_upper_treshold_o,
  output logic [AXIS_TDATA_WIDTH-1:0]       EF_lower_treshold_o,
  extremum_window_controller_if.slave       S_AXIS,
  extremum_window_controller_if.master      M_AXIS
);
  localparam int W  = AXIS_TDATA_WIDTH;
  localparam int NW = $clog2(W + 1);
  localparam logic [W-1:0] MOST_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MEASURE, EVAL, UPDATE} state_t;

  state_t        state_q, state_d;
  logic [4:0]    log_q, log_d;
  logic [5:0]    tgt_q, tgt_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [W-1:0]  min_q, min_d, max_q, max_d;
  logic [5:0]    shift_q, shift_d;
  logic [W-1:0]  upper_q, upper_d, lower_q, lower_d;
  logic [31:0]   wcnt_q, wcnt_d;
  logic          arm;
  logic [NW-1:0] n_min, n_max, n_peak;
  logic [7:0]    n8, t8;
  logic [5:0]    shift_calc;
  logic [31:0]   win_len;

  // Minimal signed width: one past the highest bit differing from the sign bit.
  function automatic logic [NW-1:0] min_width(input logic [W-1:0] v);
    logic [NW-1:0] n;
    n = NW'(1);
    for (int i = 0; i < W - 1; i++) begin
      if (v[i] != v[W-1]) n = NW'(i + 2);
    end
    return n;
  endfunction

  assign n_min      = min_width(min_q);
  assign n_max      = min_width(max_q);
  assign n_peak     = (n_min > n_max) ? n_min : n_max;
  assign n8         = 8'(n_peak);
  assign t8         = 8'(tgt_q);
  assign shift_calc = (n8 > t8) ? 6'(n8 - t8) : 6'd0;
  assign win_len    = 32'd1 << log_q;

  always_comb begin
    state_d = state_q;
    log_d   = log_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    min_d   = min_q;
    max_d   = max_q;
    shift_d = shift_q;
    upper_d = upper_q;
    lower_d = lower_q;
    wcnt_d  = wcnt_q;
    arm     = 1'b0;
    case (state_q)
      IDLE: arm = CTRL_start_i || CTRL_continuous_i;
      MEASURE: begin
        if (S_AXIS.tvalid) begin
          if ($signed(S_AXIS.tdata) < $signed(min_q)) min_d = S_AXIS.tdata;
          if ($signed(S_AXIS.tdata) > $signed(max_q)) max_d = S_AXIS.tdata;
          cnt_d = cnt_q + 32'd1;
          if (cnt_q + 32'd1 == win_len) state_d = EVAL;
        end
      end
      EVAL: begin
        // Results register on leaving EVAL so they appear together with done.
        state_d = UPDATE;
        shift_d = shift_calc;
        upper_d = $signed(max_q) >>> shift_calc;
        lower_d = $signed(min_q) >>> shift_calc;
        wcnt_d  = wcnt_q + 32'd1;
      end
      UPDATE: begin
        if (CTRL_continuous_i) arm = 1'b1;
        else                   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (arm) begin
      state_d = MEASURE;
      log_d   = (int'(CTRL_log_count_i) > MAX_LOG_COUNT) ? 5'(MAX_LOG_COUNT) : CTRL_log_count_i;
      if (CTRL_target_bits_i == 6'd0)          tgt_d = 6'd1;
      else if (int'(CTRL_target_bits_i) > W)   tgt_d = 6'(W);
      else                                     tgt_d = CTRL_target_bits_i;
      cnt_d   = 32'd0;
      min_d   = MOST_POS;
      max_d   = MOST_NEG;
    end
  end

  always_ff @(posedge SYS_aclk_i) begin
    if (!SYS_aresetn_i) begin
      state_q <= IDLE;
      log_q   <= 5'd0;
      tgt_q   <= 6'd1;
      cnt_q   <= 32'd0;
      min_q   <= MOST_POS;
      max_q   <= MOST_NEG;
      shift_q <= 6'd0;
      upper_q <= MOST_NEG;
      lower_q <= MOST_POS;
      wcnt_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      log_q   <= log_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      min_q   <= min_d;
      max_q   <= max_d;
      shift_q <= shift_d;
      upper_q <= upper_d;
      lower_q <= lower_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign CTRL_busy_o         = (state_q != IDLE);
  assign CTRL_done_o         = (state_q == UPDATE);
  assign CTRL_window_count_o = wcnt_q;
  assign EF_log_shift_o      = shift_q;
  assign EF_upper_treshold_o = upper_q;
  assign EF_lower_treshold_o = lower_q;

  assign S_AXIS.tready = 1'b1;
  assign M_AXIS.tvalid = S_AXIS.tvalid;
  assign M_AXIS.tdata  = S_AXIS.tdata;
endmodule

// File: tb/tb_extremum_window_controller.sv
// Directed bench for extremum_window_controller with hand-computed expectations.
module tb_extremum_window_controller;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, cont;
  logic [4:0]  log_count;
  logic [5:0]  target_bits;
  logic        busy, done;
  logic [31:0] wcnt;
  logic [5:0]  shift;
  logic [31:0] upper, lower;
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          base;

  extremum_window_controller_if #(.W(32)) s_if ();
  extremum_window_controller_if #(.W(32)) m_if ();

  extremum_window_controller #(.AXIS_TDATA_WIDTH(32), .MAX_LOG_COUNT(20)) dut (
    .SYS_aclk_i          (clk),
    .SYS_aresetn_i       (rst_n),
    .CTRL_start_i        (start),
    .CTRL_continuous_i   (cont),
    .CTRL_log_count_i    (log_count),
    .CTRL_target_bits_i  (target_bits),
    .CTRL_busy_o         (busy),
    .CTRL_done_o         (done),
    .CTRL_window_count_o (wcnt),
    .EF_log_shift_o      (shift),
    .EF_upper_treshold_o (upper),
    .EF_lower_treshold_o (lower),
    .S_AXIS              (s_if),
    .M_AXIS              (m_if)
  );

  assign m_if.tready = 1'b1;

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic sample(input logic [31:0] v);
    s_if.tvalid = 1'b1;
    s_if.tdata  = v;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cont = 1'b0;
    log_count = 5'd2; target_bits = 6'd8;
    s_if.tvalid = 1'b0; s_if.tdata = 32'd0;
    tick(2);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_wcnt",  wcnt,       32'd0);
    chk("rst_shift", 32'(shift), 32'd0);
    chk("rst_upper", upper,      32'h80000000);
    chk("rst_lower", lower,      32'h7FFFFFFF);
    rst_n = 1'b1;
    tick();

    // 1: single shot, L=2 T=8
    pulse_start();
    sample(32'd100);
    chk("pass_tdata",  m_if.tdata,         32'd100);
    chk("pass_tvalid", 32'(m_if.tvalid),   32'd1);
    chk("tready",      32'(s_if.tready),   32'd1);
    sample(-32'sd50);
    sample(32'd20);
    sample(-32'sd128);
    s_if.tvalid = 1'b0;
    chk("t1_eval_done", 32'(done), 32'd0);
    chk("t1_eval_busy", 32'(busy), 32'd1);
    tick();
    chk("t1_done",  32'(done),  32'd1);
    chk("t1_shift", 32'(shift), 32'd0);
    chk("t1_upper", upper,      32'd100);
    chk("t1_lower", lower,      32'hFFFFFF80);
    chk("t1_wcnt",  wcnt,       32'd1);
    tick();
    chk("t1_busy_after", 32'(busy), 32'd0);
    chk("t1_done_after", 32'(done), 32'd0);

    // 2: shift needed
    pulse_start();
    sample(32'd1000);
    sample(-32'sd3000);
    sample(32'd5);
    sample(32'd7);
    s_if.tvalid = 1'b0;
    tick();
    chk("t2_done",  32'(done),  32'd1);
    chk("t2_shift", 32'(shift), 32'd5);
    chk("t2_upper", upper,      32'd31);
    chk("t2_lower", lower,      32'hFFFFFFA2);
    chk("t2_wcnt",  wcnt,       32'd2);
    tick();

    // 3: L=3 with tvalid gaps; invalid beats carry 9999
    log_count = 5'd3;
    pulse_start();
    for (int i = 0; i < 15; i++) begin
      s_if.tvalid = (i % 2 == 0);
      s_if.tdata  = (i % 2 == 0) ? 32'((i / 2 + 1) * 10) : 32'd9999;
      tick();
      if (i == 13) begin
        chk("t3_busy_mid", 32'(busy), 32'd1);
        chk("t3_wcnt_mid", wcnt,      32'd2);
      end
    end
    s_if.tvalid = 1'b0; s_if.tdata = 32'd9999;
    chk("t3_eval_done", 32'(done), 32'd0);
    tick();
    chk("t3_done",  32'(done),  32'd1);
    chk("t3_upper", upper,      32'd80);
    chk("t3_lower", lower,      32'd10);
    chk("t3_shift", 32'(shift), 32'd0);
    chk("t3_wcnt",  wcnt,       32'd3);
    tick();

    // 4: continuous, L=1, drop continuous during window 3
    log_count = 5'd1;
    base = done_cnt;
    s_if.tvalid = 1'b1; s_if.tdata = 32'd5;
    cont = 1'b1;
    for (int c = 0; c < 40 && done_cnt < base + 2; c++) tick();
    chk("t4_two_windows", 32'(done_cnt - base), 32'd2);
    cont = 1'b0;
    for (int c = 0; c < 20 && done_cnt < base + 3; c++) tick();
    s_if.tvalid = 1'b0;
    tick(4);
    chk("t4_done_pulses", 32'(done_cnt - base), 32'd3);
    chk("t4_wcnt",  wcnt,       32'd6);
    chk("t4_busy",  32'(busy),  32'd0);
    chk("t4_upper", upper,      32'd5);
    chk("t4_lower", lower,      32'd5);

    // 5: full-scale negative at L=0, then an all-zero window at L=1
    log_count = 5'd0;
    pulse_start();
    sample(32'h80000000);
    s_if.tvalid = 1'b0;
    tick();
    chk("t5_done",  32'(done),  32'd1);
    chk("t5_shift", 32'(shift), 32'd24);
    chk("t5_lower", lower,      32'hFFFFFF80);
    chk("t5_upper", upper,      32'hFFFFFF80);
    tick();
    log_count = 5'd1;
    pulse_start();
    sample(32'd0);
    sample(32'd0);
    s_if.tvalid = 1'b0;
    tick();
    chk("t5z_shift", 32'(shift), 32'd0);
    chk("t5z_upper", upper,      32'd0);
    chk("t5z_lower", lower,      32'd0);
    chk("t5z_wcnt",  wcnt,       32'd8);
    tick();

    // 6: reset mid-window, fresh window, start ignored while busy
    log_count = 5'd4;
    pulse_start();
    for (int i = 0; i < 7; i++) sample(32'd3);
    s_if.tvalid = 1'b0;
    base = done_cnt;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(3);
    chk("t6_rst_nodone", 32'(done_cnt - base), 32'd0);
    chk("t6_rst_busy",   32'(busy),  32'd0);
    chk("t6_rst_wcnt",   wcnt,       32'd0);
    chk("t6_rst_shift",  32'(shift), 32'd0);
    chk("t6_rst_upper",  upper,      32'h80000000);
    chk("t6_rst_lower",  lower,      32'h7FFFFFFF);
    pulse_start();
    for (int i = 1; i <= 15; i++) begin
      start = (i == 5);
      sample(32'(i));
    end
    start = 1'b0;
    s_if.tvalid = 1'b0;
    tick(3);
    chk("t6_15_busy", 32'(busy), 32'd1);
    chk("t6_15_wcnt", wcnt,      32'd0);
    sample(-32'sd16);
    s_if.tvalid = 1'b0;
    tick();
    chk("t6_done",  32'(done), 32'd1);
    chk("t6_upper", upper,     32'd15);
    chk("t6_lower", lower,     32'hFFFFFFF0);
    tick(5);
    chk("t6_busy_end", 32'(busy), 32'd0);
    chk("t6_wcnt",     wcnt,      32'd1);
    chk("t6_pulses",   32'(done_cnt - base), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
